// File: rtl/i2s_tx.sv
// i2s_tx: I2S master serializer. Generates BCLK/LRCK, strobes the sample
// generator once per frame, captures its stereo word and shifts it out
// MSB-first one BCLK after each LRCK edge (left slot while LRCK=0).
module i2s_tx #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned SLOT_W    = 32,
  parameter int unsigned BCLK_HALF = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] l_data,
  input  logic [DATA_W-1:0] r_data,
  input  logic              mute,
  output logic              ena,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_sdat
);

  localparam int unsigned FRAME_W = 2 * SLOT_W;
  localparam int unsigned DIV_W   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned IDX_W   = $clog2(FRAME_W);
  localparam int unsigned POS_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(FRAME_W - 1);
  localparam logic [IDX_W-1:0] IDX_SLOT   = IDX_W'(SLOT_W);
  localparam logic [IDX_W-1:0] IDX_L_END  = IDX_W'(DATA_W);
  localparam logic [IDX_W-1:0] IDX_R_END  = IDX_W'(SLOT_W + DATA_W);

  logic [DIV_W-1:0]  r_div_cnt;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic              r_ena;
  logic              r_bclk;
  logic              r_lrck;
  logic              r_sdat;

  logic              w_div_wrap;
  logic              w_tick;
  logic              w_frame;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [DATA_W-1:0] w_hold_l_nxt;
  logic [DATA_W-1:0] w_hold_r_nxt;
  logic [IDX_W-1:0]  w_pos_l;
  logic [IDX_W-1:0]  w_pos_r;
  logic              w_lrck_nxt;
  logic              w_sdat_nxt;

  // Divider, bit counter, frame capture and serial-bit selection.
  always_comb begin
    w_div_wrap   = (r_div_cnt == DIV_LAST);
    w_tick       = w_div_wrap && r_bclk;
    w_frame      = w_tick && (r_bit_idx == IDX_LAST);
    w_div_nxt    = w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
    w_idx_nxt    = r_bit_idx;
    w_hold_l_nxt = r_hold_l;
    w_hold_r_nxt = r_hold_r;
    w_lrck_nxt   = r_lrck;
    w_sdat_nxt   = r_sdat;
    w_pos_l      = IDX_L_END - w_idx_nxt;
    w_pos_r      = IDX_R_END - w_idx_nxt;

    if (w_tick) begin
      w_idx_nxt = (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + IDX_W'(1);
    end
    w_pos_l = IDX_L_END - w_idx_nxt;
    w_pos_r = IDX_R_END - w_idx_nxt;

    if (w_frame) begin
      w_hold_l_nxt = mute ? '0 : l_data;
      w_hold_r_nxt = mute ? '0 : r_data;
    end

    // lrck/sdat change only with the falling BCLK, from the post-capture word.
    if (w_tick) begin
      w_lrck_nxt = (w_idx_nxt >= IDX_SLOT);
      w_sdat_nxt = 1'b0;
      if ((w_idx_nxt != '0) && (w_idx_nxt <= IDX_L_END)) begin
        w_sdat_nxt = w_hold_l_nxt[POS_W'(w_pos_l)];
      end else if ((w_idx_nxt > IDX_SLOT) && (w_idx_nxt <= IDX_R_END)) begin
        w_sdat_nxt = w_hold_r_nxt[POS_W'(w_pos_r)];
      end
    end
  end

  // State and registered outputs; synchronous reset restarts the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bit_idx <= IDX_LAST;
      r_hold_l  <= '0;
      r_hold_r  <= '0;
      r_ena     <= 1'b0;
      r_bclk    <= 1'b0;
      r_lrck    <= 1'b0;
      r_sdat    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_bit_idx <= w_idx_nxt;
      r_hold_l  <= w_hold_l_nxt;
      r_hold_r  <= w_hold_r_nxt;
      r_ena     <= w_frame;
      r_bclk    <= w_div_wrap ? ~r_bclk : r_bclk;
      r_lrck    <= w_lrck_nxt;
      r_sdat    <= w_sdat_nxt;
    end
  end

  assign ena      = r_ena;
  assign i2s_bclk = r_bclk;
  assign i2s_lrck = r_lrck;
  assign i2s_sdat = r_sdat;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: two serializers (BCLK_HALF=4 and 1) driven by shared random
// stimulus and compared every clock against a timeline model of the I2S frame.
module tb_i2s_tx;

  localparam int D = 24;
  localparam int S = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [D-1:0] l_data;
  logic [D-1:0] r_data;
  logic         mute;
  logic [1:0]   ena_w;
  logic [1:0]   bclk_w;
  logic [1:0]   lrck_w;
  logic [1:0]   sdat_w;

  int total = 0;
  int bad   = 0;

  // model state per instance: clocks since reset release and captured words
  int           t  [2];
  logic [D-1:0] hl [2];
  logic [D-1:0] hr [2];
  int           ena_first [2];
  int           ena_second[2];
  int           ena_seen  [2];

  always #5 clk = ~clk;

  i2s_tx #(.DATA_W(D), .SLOT_W(S), .BCLK_HALF(4)) u_dut_h4 (
    .clk      (clk),
    .reset    (reset),
    .l_data   (l_data),
    .r_data   (r_data),
    .mute     (mute),
    .ena      (ena_w[0]),
    .i2s_bclk (bclk_w[0]),
    .i2s_lrck (lrck_w[0]),
    .i2s_sdat (sdat_w[0])
  );

  i2s_tx #(.DATA_W(D), .SLOT_W(S), .BCLK_HALF(1)) u_dut_h1 (
    .clk      (clk),
    .reset    (reset),
    .l_data   (l_data),
    .r_data   (r_data),
    .mute     (mute),
    .ena      (ena_w[1]),
    .i2s_bclk (bclk_w[1]),
    .i2s_lrck (lrck_w[1]),
    .i2s_sdat (sdat_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int half_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // ena after clock t: first at 2H, then every 4*H*S
  function automatic logic exp_ena(input int i, input int tt);
    int h;
    h = half_of(i);
    return (tt >= 2 * h) && (((tt - 2 * h) % (4 * h * S)) == 0);
  endfunction

  function automatic logic exp_bclk(input int i);
    return 1'((t[i] / half_of(i)) % 2);
  endfunction

  // completed BCLK falls; frame position b = (falls-1) mod 2S
  function automatic logic exp_lrck(input int i);
    int n;
    n = t[i] / (2 * half_of(i));
    if (n == 0) return 1'b0;
    return (((n - 1) % (2 * S)) >= S);
  endfunction

  function automatic logic exp_sdat(input int i);
    int n;
    int b;
    n = t[i] / (2 * half_of(i));
    if (n == 0) return 1'b0;
    b = (n - 1) % (2 * S);
    if (b >= 1 && b <= D) return hl[i][5'(D - b)];
    if (b >= S + 1 && b <= S + D) return hr[i][5'(D - (b - S))];
    return 1'b0;
  endfunction

  // advance one clock: update the model from the inputs at this edge, then compare
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        t[i] = 0;
        hl[i] = '0;
        hr[i] = '0;
        ena_seen[i] = 0;
        ena_first[i] = -1;
        ena_second[i] = -1;
      end else begin
        t[i]++;
        if (exp_ena(i, t[i])) begin
          hl[i] = mute ? '0 : l_data;
          hr[i] = mute ? '0 : r_data;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ena%0d", i),  32'(ena_w[i]),  32'(reset ? 1'b0 : exp_ena(i, t[i])));
      check($sformatf("bclk%0d", i), 32'(bclk_w[i]), 32'(exp_bclk(i)));
      check($sformatf("lrck%0d", i), 32'(lrck_w[i]), 32'(exp_lrck(i)));
      check($sformatf("sdat%0d", i), 32'(sdat_w[i]), 32'(exp_sdat(i)));
      if (ena_w[i] && !reset) begin
        if (ena_seen[i] == 0) ena_first[i] = t[i];
        if (ena_seen[i] == 1) ena_second[i] = t[i];
        ena_seen[i]++;
      end
    end
  endtask

  initial begin
    int bound;
    reset  = 1'b1;
    l_data = '0;
    r_data = '0;
    mute   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; hl[i] = '0; hr[i] = '0;
      ena_seen[i] = 0; ena_first[i] = -1; ena_second[i] = -1;
    end

    // reset held 5 clocks: every output low
    for (int k = 0; k < 5; k++) step();
    reset = 1'b0;

    // fixed stereo pattern across several frames
    l_data = 24'hA5A5A5;
    r_data = 24'h5A5A5A;
    for (int k = 0; k < 1600; k++) step();
    check("first_ena_h4", 32'(ena_first[0]), 32'd8);
    check("ena_period_h4", 32'(ena_second[0] - ena_first[0]), 32'd512);
    check("first_ena_h1", 32'(ena_first[1]), 32'd2);
    check("ena_period_h1", 32'(ena_second[1] - ena_first[1]), 32'd128);

    // generator-style updates after each ena, plus random mid-frame churn
    for (int k = 0; k < 2000; k++) begin
      if (exp_ena(0, t[0])) begin
        l_data = D'(k);
        r_data = D'(k);
      end else if ($urandom_range(0, 3) == 0) begin
        l_data = D'($urandom);
        r_data = D'($urandom);
      end
      step();
    end

    // one-clock reset while the 4x instance sits at bit 40
    bound = 0;
    while (!((t[0] / 8) > 0 && (((t[0] / 8) - 1) % 64) == 40) && bound < 1000) begin
      step();
      bound++;
    end
    check("reach_bit40", 32'(bound < 1000), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_bclk", 32'(bclk_w[0]), 32'd0);
    check("rst_ena",  32'(ena_w[0]),  32'd0);
    for (int k = 0; k < 600; k++) step();
    check("rst_first_ena_h4", 32'(ena_first[0]), 32'd8);
    check("rst_first_ena_h1", 32'(ena_first[1]), 32'd2);

    // mute toggled mid-frame with a full-scale negative left sample
    l_data = 24'h800000;
    for (int k = 0; k < 1800; k++) begin
      if (k == 300)  mute = 1'b1;
      if (k == 1000) mute = 1'b0;
      if ($urandom_range(0, 7) == 0) r_data = D'($urandom);
      step();
    end

    // random data and mute together
    for (int k = 0; k < 1500; k++) begin
      l_data = D'($urandom);
      r_data = D'($urandom);
      if ($urandom_range(0, 199) == 0) mute = ~mute;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
